// File: rtl/loader_mem_sequencer_if.sv
// Bus bundle for loader_mem_sequencer: loader input, CPU write port, RAM write port and jump control.
// The master drives the loader/CPU inputs; the slave owns the RAM port and the CPU control outputs.
interface loader_mem_sequencer_if #(
  parameter int unsigned ADDR = 16,
  parameter int unsigned DATA = 8
) ();
  logic            loader_download;
  logic            loader_wr;
  logic [ADDR-1:0] loader_addr;
  logic [DATA-1:0] loader_data;
  logic            execute_enable;
  logic [ADDR-1:0] execute_addr;
  logic            cpu_wr;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_data;
  logic            ram_wr;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din;
  logic            cpu_hold;
  logic            cpu_jump;
  logic [ADDR-1:0] jump_addr;
  logic            busy;

  modport master (
    output loader_download, loader_wr, loader_addr, loader_data,
    output execute_enable, execute_addr,
    output cpu_wr, cpu_addr, cpu_data,
    input  ram_wr, ram_addr, ram_din, cpu_hold, cpu_jump, jump_addr, busy
  );

  modport slave (
    input  loader_download, loader_wr, loader_addr, loader_data,
    input  execute_enable, execute_addr,
    input  cpu_wr, cpu_addr, cpu_data,
    output ram_wr, ram_addr, ram_din, cpu_hold, cpu_jump, jump_addr, busy
  );
endinterface

// File: rtl/loader_mem_sequencer.sv
// Shares the RAM write port between the CPU and the CMD loader; after a download with an
// execute block it patches the entry vector in RAM and requests a CPU jump.
module loader_mem_sequencer #(
  parameter int unsigned ADDR      = 16,
  parameter int unsigned DATA      = 8,
  parameter logic [15:0] ENTRY_LSB = 16'h40DF,
  parameter logic [15:0] ENTRY_MSB = 16'h40E0,
  parameter int unsigned DRAIN     = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  loader_mem_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_PATCH_LSB,
    S_PATCH_MSB,
    S_JUMP
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            exec_pend_q, exec_pend_d;
  logic            ram_wr_q, ram_wr_d;
  logic [ADDR-1:0] ram_addr_q, ram_addr_d;
  logic [DATA-1:0] ram_din_q, ram_din_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            cpu_jump_q, cpu_jump_d;
  logic [ADDR-1:0] jump_addr_q, jump_addr_d;
  logic            busy_q, busy_d;

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      exec_pend_q <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      cpu_hold_q  <= 1'b0;
      cpu_jump_q  <= 1'b0;
      jump_addr_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exec_pend_q <= exec_pend_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_jump_q  <= cpu_jump_d;
      jump_addr_q <= jump_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exec_pend_d = exec_pend_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cpu_jump_d  = 1'b0;
    jump_addr_d = jump_addr_q;

    case (state_q)
      S_IDLE: begin
        // The cycle right after a jump still shows cpu_hold, so that CPU write is dropped
        ram_wr_d   = bus.cpu_wr & ~cpu_hold_q;
        ram_addr_d = bus.cpu_addr;
        ram_din_d  = bus.cpu_data;
        if (bus.loader_download) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ram_wr_d   = bus.loader_wr;
        ram_addr_d = bus.loader_addr;
        ram_din_d  = bus.loader_data;
        if (bus.execute_enable) begin
          exec_pend_d = 1'b1;
          jump_addr_d = bus.execute_addr;
        end
        if (!bus.loader_download) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(DRAIN);
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (bus.loader_download) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = exec_pend_q ? S_PATCH_LSB : S_IDLE;
          cnt_d   = '0;
        end
      end
      S_PATCH_LSB: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = ADDR'(ENTRY_LSB);
        ram_din_d  = DATA'(jump_addr_q[7:0]);
        state_d    = S_PATCH_MSB;
      end
      S_PATCH_MSB: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = ADDR'(ENTRY_MSB);
        ram_din_d  = DATA'(jump_addr_q[15:8]);
        state_d    = S_JUMP;
      end
      S_JUMP: begin
        cpu_jump_d  = 1'b1;
        exec_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Hold is released together with the falling edge of the jump pulse
    cpu_hold_d = (state_d != S_IDLE) || (state_q == S_JUMP);
    busy_d     = (state_d != S_IDLE);
  end

  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.cpu_jump  = cpu_jump_q;
  assign bus.jump_addr = jump_addr_q;
  assign bus.busy      = busy_q;

endmodule
